// File: rtl/clock_pkg.sv
// rtl/clock_pkg.sv - shared mode encoding and time moduli for the digital clock controller
package clock_pkg;

  typedef enum logic [2:0] {
    RUN         = 3'd0,
    SET_HRS     = 3'd1,
    SET_MIN     = 3'd2,
    SET_ALM_HRS = 3'd3,
    SET_ALM_MIN = 3'd4
  } mode_t;

  localparam int SEC_MOD = 60;
  localparam int MIN_MOD = 60;
  localparam int HRS_MOD = 24;

endpackage

// File: rtl/alarm_unit.sv
// rtl/alarm_unit.sv - alarm hour/minute registers, arming, match edge detect and buzzer timeout
module alarm_unit
  import clock_pkg::*;
#(
  parameter int W         = 7,
  parameter int HRS_MOD   = 24,
  parameter int MIN_MOD   = 60,
  parameter int BUZZ_SECS = 60
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  mode_t        i_mode,
  input  logic         i_tick_1hz,
  input  logic         i_inc_hrs,
  input  logic         i_inc_min,
  input  logic         i_btn_alm,
  input  logic         i_cancel,
  input  logic [W-1:0] i_cur_sec,
  input  logic [W-1:0] i_cur_min,
  input  logic [W-1:0] i_cur_hrs,
  output logic [W-1:0] o_alm_min,
  output logic [W-1:0] o_alm_hrs,
  output logic         o_alm_armed,
  output logic         o_buzz
);

  localparam int CW = (BUZZ_SECS > 1) ? $clog2(BUZZ_SECS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BUZZ_SECS - 1);

  logic [W-1:0]  r_alm_min;
  logic [W-1:0]  r_alm_hrs;
  logic          r_armed;
  logic          r_buzz;
  logic          r_match_q;
  logic [CW-1:0] r_cnt;

  logic [W-1:0]  w_hrs_nxt;
  logic [W-1:0]  w_min_nxt;
  logic          w_match;
  logic          w_fire;

  assign w_hrs_nxt = (r_alm_hrs == W'(HRS_MOD - 1)) ? '0 : r_alm_hrs + W'(1);
  assign w_min_nxt = (r_alm_min == W'(MIN_MOD - 1)) ? '0 : r_alm_min + W'(1);

  // Only the rising edge of a match fires, so a held 00 seconds cannot re-trigger.
  assign w_match = r_armed && (i_mode == RUN) && (i_cur_sec == '0) &&
                   (i_cur_min == r_alm_min) && (i_cur_hrs == r_alm_hrs);
  assign w_fire  = w_match && !r_match_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_alm_min <= '0;
      r_alm_hrs <= '0;
      r_armed   <= 1'b0;
      r_buzz    <= 1'b0;
      r_match_q <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_match_q <= w_match;
      if (i_inc_hrs) r_alm_hrs <= w_hrs_nxt;
      if (i_inc_min) r_alm_min <= w_min_nxt;
      if (i_btn_alm) r_armed <= ~r_armed;

      if (i_btn_alm && r_armed) begin
        r_buzz <= 1'b0;
        r_cnt  <= '0;
      end else if (w_fire) begin
        r_buzz <= 1'b1;
        r_cnt  <= '0;
      end else if (r_buzz) begin
        if (i_cancel) begin
          r_buzz <= 1'b0;
        end else if (i_tick_1hz) begin
          if (r_cnt == CNT_LAST) r_buzz <= 1'b0;
          else                   r_cnt  <= r_cnt + CW'(1);
        end
      end
    end
  end

  assign o_alm_min   = r_alm_min;
  assign o_alm_hrs   = r_alm_hrs;
  assign o_alm_armed = r_armed;
  assign o_buzz      = r_buzz;

endmodule

// File: rtl/clock_mode_ctrl.sv
// rtl/clock_mode_ctrl.sv - set-mode FSM and counter enable decode for the lab digital clock
module clock_mode_ctrl
  import clock_pkg::*;
#(
  parameter int W         = 7,
  parameter int HRS_MOD   = 24,
  parameter int MIN_MOD   = 60,
  parameter int BUZZ_SECS = 60
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         tick_1hz,
  input  logic         btn_set,
  input  logic         btn_inc,
  input  logic         btn_alm,
  input  logic         sec_z,
  input  logic         min_z,
  input  logic [W-1:0] cur_sec,
  input  logic [W-1:0] cur_min,
  input  logic [W-1:0] cur_hrs,
  output logic         sec_en,
  output logic         min_en,
  output logic         hrs_en,
  output logic         sec_clr,
  output logic [W-1:0] alm_min,
  output logic [W-1:0] alm_hrs,
  output logic         alm_armed,
  output logic         buzz,
  output logic [2:0]   mode
);

  mode_t r_mode;
  logic  r_sec_clr;

  logic  w_buzz;
  logic  w_set;
  logic  w_inc;
  logic  w_sec_en;
  logic  w_min_en;
  logic  w_hrs_en;

  // While buzzing, set/inc only silence the buzzer; otherwise set outranks inc.
  assign w_set = btn_set && !w_buzz;
  assign w_inc = btn_inc && !btn_set && !w_buzz;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mode    <= RUN;
      r_sec_clr <= 1'b0;
    end else begin
      r_sec_clr <= 1'b0;
      case (r_mode)
        RUN: begin
          if (w_set) begin
            r_mode    <= SET_HRS;
            r_sec_clr <= 1'b1;
          end
        end
        SET_HRS:     if (w_set) r_mode <= SET_MIN;
        SET_MIN:     if (w_set) r_mode <= SET_ALM_HRS;
        SET_ALM_HRS: if (w_set) r_mode <= SET_ALM_MIN;
        SET_ALM_MIN: if (w_set) r_mode <= RUN;
        default:     r_mode <= RUN;
      endcase
    end
  end

  always_comb begin
    w_sec_en = 1'b0;
    w_min_en = 1'b0;
    w_hrs_en = 1'b0;
    if (!rst) begin
      case (r_mode)
        RUN: begin
          w_sec_en = tick_1hz;
          w_min_en = sec_z;
          w_hrs_en = min_z;
        end
        SET_HRS: w_hrs_en = w_inc;
        SET_MIN: w_min_en = w_inc;
        default: ;
      endcase
    end
  end

  alarm_unit #(
    .W         (W),
    .HRS_MOD   (HRS_MOD),
    .MIN_MOD   (MIN_MOD),
    .BUZZ_SECS (BUZZ_SECS)
  ) u_alarm (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_mode      (r_mode),
    .i_tick_1hz  (tick_1hz),
    .i_inc_hrs   (w_inc && (r_mode == SET_ALM_HRS)),
    .i_inc_min   (w_inc && (r_mode == SET_ALM_MIN)),
    .i_btn_alm   (btn_alm),
    .i_cancel    (btn_set || btn_inc),
    .i_cur_sec   (cur_sec),
    .i_cur_min   (cur_min),
    .i_cur_hrs   (cur_hrs),
    .o_alm_min   (alm_min),
    .o_alm_hrs   (alm_hrs),
    .o_alm_armed (alm_armed),
    .o_buzz      (w_buzz)
  );

  assign sec_en  = w_sec_en;
  assign min_en  = w_min_en;
  assign hrs_en  = w_hrs_en;
  assign sec_clr = r_sec_clr && !rst;
  assign buzz    = w_buzz;
  assign mode    = r_mode;

endmodule

// File: tb/tb_clock_mode_ctrl.sv
// tb/tb_clock_mode_ctrl.sv - directed self-checking bench for clock_mode_ctrl
module tb_clock_mode_ctrl;

  logic       clk;
  logic       rst;
  logic       tick_1hz;
  logic       btn_set;
  logic       btn_inc;
  logic       btn_alm;
  logic       sec_z;
  logic       min_z;
  logic [6:0] cur_sec;
  logic [6:0] cur_min;
  logic [6:0] cur_hrs;
  logic       sec_en;
  logic       min_en;
  logic       hrs_en;
  logic       sec_clr;
  logic [6:0] alm_min;
  logic [6:0] alm_hrs;
  logic       alm_armed;
  logic       buzz;
  logic [2:0] mode;

  int n_pass;
  int n_total;

  clock_mode_ctrl #(.W(7), .HRS_MOD(24), .MIN_MOD(60), .BUZZ_SECS(60)) dut (
    .clk       (clk),
    .rst       (rst),
    .tick_1hz  (tick_1hz),
    .btn_set   (btn_set),
    .btn_inc   (btn_inc),
    .btn_alm   (btn_alm),
    .sec_z     (sec_z),
    .min_z     (min_z),
    .cur_sec   (cur_sec),
    .cur_min   (cur_min),
    .cur_hrs   (cur_hrs),
    .sec_en    (sec_en),
    .min_en    (min_en),
    .hrs_en    (hrs_en),
    .sec_clr   (sec_clr),
    .alm_min   (alm_min),
    .alm_hrs   (alm_hrs),
    .alm_armed (alm_armed),
    .buzz      (buzz),
    .mode      (mode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_pulses();
    tick_1hz = 1'b0;
    btn_set  = 1'b0;
    btn_inc  = 1'b0;
    btn_alm  = 1'b0;
    sec_z    = 1'b0;
    min_z    = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick_1hz = 1'b1;
    cyc();
    cyc();
    n_total++; if (sec_en !== 1'b0) $display("FAIL reset_sec_en got %b want 0", sec_en); else n_pass++;
    n_total++; if (sec_clr !== 1'b0) $display("FAIL reset_sec_clr got %b want 0", sec_clr); else n_pass++;
    n_total++; if (mode !== 3'd0) $display("FAIL reset_mode got %0d want 0", mode); else n_pass++;
    n_total++; if ({alm_armed, buzz} !== 2'b00) $display("FAIL reset_armed_buzz got %b want 00", {alm_armed, buzz}); else n_pass++;
    n_total++; if ({alm_hrs, alm_min} !== 14'd0) $display("FAIL reset_alarm got %0d:%0d want 0:0", alm_hrs, alm_min); else n_pass++;
    tick_1hz = 1'b0;
    rst = 1'b0;
    cyc();
  endtask

  task automatic test_run_ticks();
    int pulses = 0;
    int stray = 0;
    for (int i = 0; i < 3; i++) begin
      tick_1hz = 1'b1;
      #1;
      if (sec_en === 1'b1) pulses++;
      cyc();
      tick_1hz = 1'b0;
      #1;
      if (sec_en !== 1'b0) stray++;
      cyc();
    end
    n_total++; if (pulses !== 3) $display("FAIL run_sec_en_pulses got %0d want 3", pulses); else n_pass++;
    n_total++; if (stray !== 0) $display("FAIL run_sec_en_stray got %0d want 0", stray); else n_pass++;
    n_total++; if (mode !== 3'd0 || buzz !== 1'b0) $display("FAIL run_mode_buzz got %0d/%b want 0/0", mode, buzz); else n_pass++;
  endtask

  task automatic test_carry();
    sec_z = 1'b1;
    #1;
    n_total++; if ({min_en, hrs_en} !== 2'b10) $display("FAIL carry_sec_z got %b want 10", {min_en, hrs_en}); else n_pass++;
    cyc();
    sec_z = 1'b0;
    min_z = 1'b1;
    #1;
    n_total++; if ({min_en, hrs_en} !== 2'b01) $display("FAIL carry_min_z got %b want 01", {min_en, hrs_en}); else n_pass++;
    cyc();
    min_z = 1'b0;
    #1;
    n_total++; if ({min_en, hrs_en} !== 2'b00) $display("FAIL carry_idle got %b want 00", {min_en, hrs_en}); else n_pass++;
    cyc();
  endtask

  task automatic test_set_hrs();
    int pulses = 0;
    btn_set = 1'b1;
    cyc();
    btn_set = 1'b0;
    n_total++; if (mode !== 3'd1) $display("FAIL set_hrs_mode got %0d want 1", mode); else n_pass++;
    n_total++; if (sec_clr !== 1'b1) $display("FAIL set_hrs_sec_clr got %b want 1", sec_clr); else n_pass++;
    cyc();
    n_total++; if (sec_clr !== 1'b0) $display("FAIL set_hrs_sec_clr_len got %b want 0", sec_clr); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      btn_inc = 1'b1;
      #1;
      if (hrs_en === 1'b1 && min_en === 1'b0) pulses++;
      cyc();
      btn_inc = 1'b0;
      cyc();
    end
    n_total++; if (pulses !== 3) $display("FAIL set_hrs_inc_pulses got %0d want 3", pulses); else n_pass++;
    tick_1hz = 1'b1;
    sec_z = 1'b1;
    #1;
    n_total++; if ({sec_en, min_en} !== 2'b00) $display("FAIL set_hrs_frozen got %b want 00", {sec_en, min_en}); else n_pass++;
    cyc();
    clear_pulses();
    cyc();
  endtask

  task automatic test_set_and_inc();
    btn_set = 1'b1;
    btn_inc = 1'b1;
    #1;
    n_total++; if ({hrs_en, min_en} !== 2'b00) $display("FAIL set_inc_same_cycle got %b want 00", {hrs_en, min_en}); else n_pass++;
    cyc();
    clear_pulses();
    n_total++; if (mode !== 3'd2) $display("FAIL set_inc_mode got %0d want 2", mode); else n_pass++;
    btn_inc = 1'b1;
    #1;
    n_total++; if ({min_en, hrs_en} !== 2'b10) $display("FAIL set_min_inc got %b want 10", {min_en, hrs_en}); else n_pass++;
    cyc();
    btn_inc = 1'b0;
    min_z = 1'b1;
    #1;
    n_total++; if (hrs_en !== 1'b0) $display("FAIL set_min_no_carry got %b want 0", hrs_en); else n_pass++;
    cyc();
    clear_pulses();
  endtask

  task automatic test_alarm_set();
    btn_set = 1'b1;
    cyc();
    btn_set = 1'b0;
    n_total++; if (mode !== 3'd3) $display("FAIL alm_mode3 got %0d want 3", mode); else n_pass++;
    btn_inc = 1'b1;
    repeat (7) cyc();
    btn_inc = 1'b0;
    n_total++; if (alm_hrs !== 7'd7) $display("FAIL alm_hrs_7 got %0d want 7", alm_hrs); else n_pass++;
    btn_inc = 1'b1;
    repeat (17) cyc();
    btn_inc = 1'b0;
    n_total++; if (alm_hrs !== 7'd0) $display("FAIL alm_hrs_wrap got %0d want 0", alm_hrs); else n_pass++;
    btn_inc = 1'b1;
    repeat (7) cyc();
    btn_set = 1'b1;
    btn_inc = 1'b0;
    cyc();
    btn_set = 1'b0;
    n_total++; if (mode !== 3'd4 || alm_hrs !== 7'd7) $display("FAIL alm_mode4 got %0d/%0d want 4/7", mode, alm_hrs); else n_pass++;
    btn_inc = 1'b1;
    repeat (60) cyc();
    btn_inc = 1'b0;
    n_total++; if (alm_min !== 7'd0) $display("FAIL alm_min_wrap got %0d want 0", alm_min); else n_pass++;
    btn_inc = 1'b1;
    repeat (5) cyc();
    btn_inc = 1'b0;
    n_total++; if (alm_min !== 7'd5) $display("FAIL alm_min_5 got %0d want 5", alm_min); else n_pass++;
    btn_set = 1'b1;
    cyc();
    btn_set = 1'b0;
    btn_alm = 1'b1;
    cyc();
    btn_alm = 1'b0;
    n_total++; if (mode !== 3'd0 || alm_armed !== 1'b1) $display("FAIL alm_armed got %0d/%b want 0/1", mode, alm_armed); else n_pass++;
  endtask

  task automatic fire_alarm();
    cur_sec = 7'd1;
    cyc();
    cur_sec = 7'd0;
    cyc();
  endtask

  task automatic test_alarm_fire();
    cur_hrs = 7'd7;
    cur_min = 7'd5;
    cur_sec = 7'd0;
    #1;
    n_total++; if (buzz !== 1'b0) $display("FAIL fire_latency got %b want 0", buzz); else n_pass++;
    cyc();
    n_total++; if (buzz !== 1'b1) $display("FAIL fire_buzz got %b want 1", buzz); else n_pass++;
    repeat (3) cyc();
    n_total++; if (buzz !== 1'b1) $display("FAIL fire_hold got %b want 1", buzz); else n_pass++;
    cur_sec = 7'd1;
    tick_1hz = 1'b1;
    #1;
    n_total++; if (sec_en !== 1'b1) $display("FAIL buzz_clock_runs got %b want 1", sec_en); else n_pass++;
    cyc();
    tick_1hz = 1'b0;
    cyc();
    for (int i = 1; i < 59; i++) begin
      tick_1hz = 1'b1;
      cyc();
      tick_1hz = 1'b0;
      cyc();
    end
    n_total++; if (buzz !== 1'b1) $display("FAIL buzz_after_59 got %b want 1", buzz); else n_pass++;
    tick_1hz = 1'b1;
    cyc();
    tick_1hz = 1'b0;
    n_total++; if (buzz !== 1'b0) $display("FAIL buzz_after_60 got %b want 0", buzz); else n_pass++;
    cyc();
  endtask

  task automatic test_buzz_cancel();
    fire_alarm();
    n_total++; if (buzz !== 1'b1) $display("FAIL refire_buzz got %b want 1", buzz); else n_pass++;
    btn_inc = 1'b1;
    #1;
    n_total++; if ({sec_en, min_en, hrs_en} !== 3'b000) $display("FAIL cancel_inc_enables got %b want 000", {sec_en, min_en, hrs_en}); else n_pass++;
    cyc();
    btn_inc = 1'b0;
    n_total++; if (buzz !== 1'b0 || mode !== 3'd0) $display("FAIL cancel_inc got %b/%0d want 0/0", buzz, mode); else n_pass++;
    fire_alarm();
    btn_set = 1'b1;
    cyc();
    btn_set = 1'b0;
    n_total++; if (buzz !== 1'b0 || mode !== 3'd0 || sec_clr !== 1'b0) $display("FAIL cancel_set got %b/%0d/%b want 0/0/0", buzz, mode, sec_clr); else n_pass++;
    fire_alarm();
    btn_alm = 1'b1;
    cyc();
    btn_alm = 1'b0;
    n_total++; if (buzz !== 1'b0 || alm_armed !== 1'b0) $display("FAIL disarm got %b/%b want 0/0", buzz, alm_armed); else n_pass++;
    fire_alarm();
    cyc();
    n_total++; if (buzz !== 1'b0) $display("FAIL disarmed_no_fire got %b want 0", buzz); else n_pass++;
    cur_sec = 7'd30;
  endtask

  task automatic test_reset_mid_set();
    btn_set = 1'b1;
    cyc();
    btn_set = 1'b0;
    cyc();
    btn_set = 1'b1;
    cyc();
    btn_set = 1'b0;
    n_total++; if (mode !== 3'd2) $display("FAIL midset_mode got %0d want 2", mode); else n_pass++;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    n_total++; if (mode !== 3'd0 || alm_hrs !== 7'd0 || alm_min !== 7'd0) $display("FAIL midset_reset got %0d %0d:%0d want 0 0:0", mode, alm_hrs, alm_min); else n_pass++;
    cyc();
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst     = 1'b1;
    clear_pulses();
    cur_sec = 7'd30;
    cur_min = 7'd0;
    cur_hrs = 7'd0;
    test_reset();
    test_run_ticks();
    test_carry();
    test_set_hrs();
    test_set_and_inc();
    test_alarm_set();
    test_alarm_fire();
    test_buzz_cancel();
    test_reset_mid_set();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
